truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential self-test engine for combinational logic blocks with N_IN inputs and one output.
- On start, it applies all 2^N_IN input vectors in ascending order and holds each for DWELL clocks.
- At the end of each hold it samples the DUT output and compares it against the expected truth table in TT_EXP.
- It counts mismatches, captures the first failing vector, and reports pass or fail. It replaces exhaustive sweeps that are currently done only in simulation benches.

Parameters:
- N_IN, 4, number of DUT inputs; 1..8.
- TT_EXP, 16'hF830, expected output truth table, width 2^N_IN; bit i is the expected F for input vector i. The default is F=A(CD+B)+BC', with A = vec[3] and D = vec[0].
- DWELL, 3, clocks each vector is held before it is sampled; must be at least 1.
- STOP_ON_ERR, 0, when 1 the sweep ends at the first mismatch.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a sweep; sampled only in IDLE or DONE.
- vec_out, out, N_IN: vector driven to the DUT inputs.
- dut_f, in, 1: DUT output, sampled synchronously.
- busy, out, 1: high while a sweep is in progress.
- done, out, 1: one-cycle pulse when a sweep ends.
- pass, out, 1: 1 if the last sweep had zero mismatches; valid from done and held until the next start.
- err_cnt, out, N_IN+1: mismatch count for the current or last sweep.
- first_err_valid, out, 1: at least one mismatch seen.
- first_err_vec, out, N_IN: vector of the first mismatch.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0, dwell counter=0.
  - Reset mid-sweep aborts the sweep immediately. No done pulse is produced and results are cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - Next state is RUN; busy<=1, vec_out<=0, dwell_cnt<=0.
  - err_cnt, first_err_valid, first_err_vec and pass are all cleared to 0.
- RUN:
  - Each vector is held for exactly DWELL cycles.
  - On each edge where dwell_cnt != DWELL-1: dwell_cnt increments.
  - On the edge where dwell_cnt == DWELL-1 (the sample edge):
    - mismatch = dut_f XOR TT_EXP[vec_out].
    - If mismatch: err_cnt increments.
    - If mismatch and first_err_valid was 0: first_err_vec<=vec_out and first_err_valid<=1.
- RUN sample-edge transitions:
  - If vec_out == 2^N_IN-1, or (STOP_ON_ERR=1 and mismatch): next state DONE, busy<=0, done<=1, pass<=(err_cnt==0 and no mismatch on this edge).
  - Otherwise: vec_out<=vec_out+1 and dwell_cnt<=0.
- Latency: with no early stop, done is high in the cycle after edge k + 2^N_IN*DWELL.
- DONE:
  - done is 1 for exactly one cycle, then 0.
  - Results and vec_out hold their last values.
  - start re-arms a sweep.
- Start handling:
  - start while busy is ignored; there is no restart.
  - start held high continuously re-triggers a sweep on the edge after each DONE entry.
- Width:
  - err_cnt is N_IN+1 bits, so it holds up to 2^N_IN with no saturation logic.
  - vec_out never wraps, because the sweep ends at the all-ones vector.
- dut_f is used raw; the DUT is assumed to settle within DWELL-1 cycles.

Test Plan:
- Correct DUT: model F=AB+ACD+BC' combinationally on vec_out, defaults, pulse start.
  - done fires 48 cycles after the start edge.
  - pass=1, err_cnt=0, first_err_valid=0.
  - vec_out visits 0..15, each vector held 3 cycles.
- Stuck-at-0 DUT (dut_f=0):
  - err_cnt=7 (ones in 16'hF830), first_err_vec=4, pass=0.
- STOP_ON_ERR=1 with a DUT that inverts F only at vector 11:
  - done fires 36 cycles after start.
  - err_cnt=1, first_err_vec=11, vec_out holds 11.
- Reset at vector 6 of a sweep:
  - All outputs go to 0 asynchronously and there is no done pulse.
  - A following start yields a full 48-cycle sweep.
- Parameter sweep N_IN=3, DWELL=1, TT_EXP=8'h96 with a parity DUT:
  - done fires 8 cycles after start and pass=1.
  - start pulsed during busy has no effect.
- Back-to-back runs: start held high with a stuck-at-1 DUT.
  - Second sweep clears err_cnt at its start, then ends with err_cnt=9 and first_err_vec=0.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table self-test engine: walks every input vector in ascending order, holds each
// for DWELL clocks, then compares the DUT output against TT_EXP and records the results.
module truth_table_sweeper #(
    parameter int unsigned                N_IN        = 4,
    parameter logic [(2**N_IN)-1:0]       TT_EXP      = 16'hF830,
    parameter int unsigned                DWELL       = 3,
    parameter bit                         STOP_ON_ERR = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_f,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_vec
);

    // Keep the dwell counter at least one bit wide so DWELL=1 still elaborates.
    localparam int unsigned   DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state;
    logic [DW-1:0] dwell_cnt;
    logic          mismatch;
    logic          last_vec;
    logic          err_zero;

    assign mismatch = dut_f ^ TT_EXP[vec_out];
    assign last_vec = &vec_out;
    assign err_zero = (err_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            vec_out         <= '0;
            dwell_cnt       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        state           <= StRun;
                        busy            <= 1'b1;
                        vec_out         <= '0;
                        dwell_cnt       <= '0;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                    end
                end
                StRun: begin
                    if (dwell_cnt != DWELL_LAST) begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end else begin
                        // Sample edge: the DUT has had DWELL-1 cycles to settle on vec_out.
                        if (mismatch) begin
                            err_cnt <= err_cnt + (N_IN + 1)'(1);
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_vec   <= vec_out;
                            end
                        end
                        if (last_vec || (STOP_ON_ERR && mismatch)) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= err_zero && !mismatch;
                        end else begin
                            vec_out   <= vec_out + N_IN'(1);
                            dwell_cnt <= '0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: three configurations, a result scoreboard filled at
// start time from an independent model of F and drained when each sweep reports done.
module tb_truth_table_sweeper;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    int   sel   = 0;
    int   mode  = 0;
    int   cyc   = 0;
    int   start_cyc = 0;
    int   n_assert  = 0;
    int   n_fail    = 0;

    typedef struct {
        int err;
        bit fev;
        int fevec;
        bit pass;
        int lat;
        int last_vec;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // F = AB + ACD + BC', A = v[3], D = v[0]
    function automatic logic f_ref(input logic [3:0] v);
        return (v[3] & v[2]) | (v[3] & v[1] & v[0]) | (v[2] & ~v[1]);
    endfunction

    logic [3:0] vec0, fevec0, vec1, fevec1;
    logic [2:0] vec2, fevec2;
    logic [4:0] err0, err1;
    logic [3:0] err2;
    logic busy0, done0, pass0, fev0, f0;
    logic busy1, done1, pass1, fev1, f1;
    logic busy2, done2, pass2, fev2, f2;

    assign f0 = (mode == 0) ? f_ref(vec0) : (mode == 1) ? 1'b0 : 1'b1;
    assign f1 = f_ref(vec1) ^ (vec1 == 4'd11);
    assign f2 = ^vec2;

    truth_table_sweeper u0 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .vec_out(vec0), .dut_f(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_valid(fev0), .first_err_vec(fevec0)
    );

    truth_table_sweeper #(.STOP_ON_ERR(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .vec_out(vec1), .dut_f(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_valid(fev1), .first_err_vec(fevec1)
    );

    truth_table_sweeper #(.N_IN(3), .TT_EXP(8'h96), .DWELL(1)) u2 (
        .clk(clk), .rst(rst), .start(start && sel == 2), .vec_out(vec2), .dut_f(f2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_valid(fev2), .first_err_vec(fevec2)
    );

    logic [3:0] vec_m, fevec_m;
    logic [4:0] err_m;
    logic       busy_m, done_m, pass_m, fev_m;

    assign vec_m   = (sel == 0) ? vec0   : (sel == 1) ? vec1   : {1'b0, vec2};
    assign fevec_m = (sel == 0) ? fevec0 : (sel == 1) ? fevec1 : {1'b0, fevec2};
    assign err_m   = (sel == 0) ? err0   : (sel == 1) ? err1   : {1'b0, err2};
    assign busy_m  = (sel == 0) ? busy0  : (sel == 1) ? busy1  : busy2;
    assign done_m  = (sel == 0) ? done0  : (sel == 1) ? done1  : done2;
    assign pass_m  = (sel == 0) ? pass0  : (sel == 1) ? pass1  : pass2;
    assign fev_m   = (sel == 0) ? fev0   : (sel == 1) ? fev1   : fev2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // md: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted at vector 11 with early stop,
    // 4 three-input parity with DWELL=1
    function automatic exp_t predict(input int md);
        exp_t e;
        int   n;
        int   dw;
        bit   want;
        bit   got;
        n = (md == 4) ? 8 : 16;
        dw = (md == 4) ? 1 : 3;
        e.err = 0; e.fev = 0; e.fevec = 0; e.pass = 0; e.lat = 0; e.last_vec = 0;
        for (int v = 0; v < n; v++) begin
            want = (md == 4) ? ^v[2:0] : f_ref(v[3:0]);
            case (md)
                1:       got = 1'b0;
                2:       got = 1'b1;
                3:       got = want ^ (v == 11);
                default: got = want;
            endcase
            e.last_vec = v;
            e.lat = (v + 1) * dw;
            if (got != want) begin
                e.err++;
                if (!e.fev) begin
                    e.fev = 1'b1;
                    e.fevec = v;
                end
                if (md == 3) break;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_vec"}, vec_m, 0);
        check({tag, "_busy"}, busy_m, 0);
        check({tag, "_done"}, done_m, 0);
        check({tag, "_pass"}, pass_m, 0);
        check({tag, "_err"}, err_m, 0);
        check({tag, "_fev"}, fev_m, 0);
        check({tag, "_fevec"}, fevec_m, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_check(input string tag, input int dw, input bit held);
        exp_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done_m) begin
                seen = 1'b1;
            end else begin
                check({tag, "_vec_walk"}, vec_m, (cyc - start_cyc) / dw);
                @(negedge clk);
            end
        end
        lat = cyc - start_cyc;
        check({tag, "_done_seen"}, seen, 1);
        e = sb.pop_front();
        if (seen) begin
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_err"}, err_m, e.err);
            check({tag, "_fev"}, fev_m, e.fev);
            check({tag, "_fevec"}, fevec_m, e.fevec);
            check({tag, "_pass"}, pass_m, e.pass);
            check({tag, "_vec_hold"}, vec_m, e.last_vec);
            @(negedge clk);
            check({tag, "_done_1cyc"}, done_m, 0);
            check({tag, "_busy_after"}, busy_m, held);
        end
    endtask

    initial begin
        bit flag;
        bit reached;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        sel = 0; mode = 0;
        sb.push_back(predict(0));
        pulse_start();
        run_check("good", 3, 1'b0);

        mode = 1;
        sb.push_back(predict(1));
        pulse_start();
        run_check("stuck0", 3, 1'b0);

        sel = 1;
        sb.push_back(predict(3));
        pulse_start();
        run_check("stop_err", 3, 1'b0);

        // Abort partway through a failing sweep, once errors have already been recorded.
        sel = 0; mode = 1;
        pulse_start();
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (vec_m == 4'd6) reached = 1'b1;
            else @(negedge clk);
        end
        check("mid_reached_vec6", reached, 1);
        check("mid_err_before_rst", err_m, 2);
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_m) flag = 1'b1;
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_m) flag = 1'b1;
        end
        check("mid_no_done", flag, 0);
        mode = 0;
        sb.push_back(predict(0));
        pulse_start();
        run_check("post_rst", 3, 1'b0);

        // A second start while busy must not restart the sweep.
        sel = 2;
        sb.push_back(predict(4));
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("n3_busy_at_restart", busy_m, 1);
        run_check("n3", 1, 1'b0);

        // Start held high: the sweep re-arms on the edge after DONE and clears the count.
        sel = 0; mode = 2;
        sb.push_back(predict(2));
        sb.push_back(predict(2));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        run_check("b2b_first", 3, 1'b1);
        start_cyc = cyc;
        check("b2b_err_cleared", err_m, 0);
        check("b2b_fev_cleared", fev_m, 0);
        start = 1'b0;
        run_check("b2b_second", 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
